alu_muldiv: RTL and testbench
=============================

Name: alu_muldiv

Overview:
- Parametrised, handshaked successor to the single-cycle datapath ALU.
- Executes base R-type, load/store address and branch-compare operations, plus the RV32M multiply/divide group, in the EX stage.
- Base ops complete in one cycle. MUL*/DIV*/REM* run iteratively over multiple cycles.
- A valid/ready interface lets the pipeline stall EX while the unit is busy. A flush input squashes in-flight work on branch mispredict.

Parameters:
- data_width, 32, operand/result width; must be even and >= 8.
- mul_step_bits, 1, multiplier bits retired per iterative-multiply cycle (1, 2 or 4); must divide data_width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous squash of accepted/in-flight op
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept a request this cycle
- alu_op  in  2  00 add (ld/st), 01 sub (branch), 10 R-type, 11 reserved
- funct3  in  3  R-type function
- funct7  in  7  0000000 base, 0100000 sub/sra, 0000001 M-extension
- operand_A  in  data_width  rs1 value
- operand_B  in  data_width  rs2/immediate value
- out_valid  out  1  result held valid
- out_ready  in  1  consumer accepts result
- result  out  data_width  registered result
- zero_flag  out  1  result == 0, registered alongside result
- busy  out  1  iterative operation in progress

Behaviour:
- Reset: state IDLE; out_valid=0, result=0, zero_flag=0, busy=0; internal accumulators cleared. in_ready=1 once reset is deasserted.
- Accept: a transfer occurs when in_valid && in_ready.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This allows back-to-back issue of base ops at 1 op/cycle.
- States:
  - IDLE → DONE on accepting a base op, or a div/rem by zero.
  - IDLE → BUSY on accepting MUL*/DIV*/REM*.
  - BUSY → DONE when the iteration count expires.
  - DONE → IDLE when out_ready and no new accept.
  - DONE → DONE/BUSY when out_ready and a new accept occurs.
- Base ops (funct7 0000000/0100000, funct3):
  - 000 add/sub
  - 001 sll
  - 010 slt
  - 011 sltu
  - 100 xor
  - 101 srl/sra
  - 110 or
  - 111 and
  - Shift amount is operand_B[$clog2(data_width)-1:0].
  - Illegal funct7/funct3 combinations and alu_op=11 produce result 0.
- Base-op latency: out_valid asserted the cycle after accept.
- M ops (funct7 0000001, funct3):
  - 000 mul
  - 001 mulh
  - 010 mulhsu
  - 011 mulhu
  - 100 div
  - 101 divu
  - 110 rem
  - 111 remu
- Multiply: signed operands are converted to magnitudes; shift-add of mul_step_bits per cycle over a 2*data_width product; sign is corrected in the final cycle. Latency = data_width/mul_step_bits + 1 cycles from accept to out_valid. mul returns the low half; mulh* return the high half.
- Divide: restoring, 1 quotient bit per cycle. Latency = data_width + 1 cycles. Signs are fixed up at the end: remainder takes the dividend's sign.
- Divide by zero: quotient = all ones, remainder = dividend. Completes with 1-cycle latency, no iteration.
- Signed overflow (most-negative / -1): quotient = most-negative, remainder = 0, via the normal iteration path.
- Result hold: result and zero_flag stay stable while out_valid && !out_ready. busy=1 only in BUSY.
- Flush:
  - Next state is IDLE and out_valid=0; an in-flight iteration is discarded.
  - A request presented in the same cycle as flush is not accepted.
  - flush takes priority over completion.
- Reset asserted mid-iteration: immediate return to reset values. No partial result is ever presented.

Optional Feature:
- FAST_MUL_EN defined: MUL/MULH/MULHSU/MULHU use a single-cycle combinational 2*data_width multiplier. Latency is 1 cycle, the same as base ops, and mul_step_bits is ignored.
- FAST_MUL_EN undefined: iterative multiplier as above. Divide is iterative in both builds.

Decomposition:
- Shared package alu_pkg holds:
  - ALUOP_* constants (00/01/10/11)
  - F7_BASE, F7_ALT, F7_MULDIV
  - funct3 encodings for base and M ops
  - state enum {IDLE, BUSY, DONE}
  - DIV0_QUOT constant
- One sub-module, muldiv_iter: owns the iteration counter, accumulator/remainder registers and sign fix-up, with a start/done interface. The top level owns decode, base ops, handshake and the FSM.

Test Plan (data_width=32, mul_step_bits=1 unless stated):
- Base op, back-to-back: R-type add 7+5, then sub 5-5 (funct7 0100000) on consecutive cycles, with out_ready=1 → result 12 then 0, zero_flag 0 then 1; in_ready held high throughout.
- Signed multiply: mulh 0x80000000 × 0x80000000 → result 0x40000000 after 33 cycles; busy high for 32 cycles; in_ready low while busy. With mul_step_bits=4 → 9 cycles.
- Signed divide: div −7/2 → result −3 (0xFFFFFFFD); rem −7/2 → result −1. Each has 33-cycle latency.
- Divide boundaries: divu 100/0 → 0xFFFFFFFF; remu 100/0 → 100, both with 1-cycle latency. div 0x80000000/−1 → 0x80000000; rem of the same → 0.
- Backpressure: hold out_ready=0 for 5 cycles after a mul completes → result stable, in_ready=0; out_ready=1 → in_ready rises the same cycle.
- Flush and reset mid-operation: flush at cycle 10 of a div → out_valid never asserts, in_ready=1 the next cycle. Async reset mid-mul → all outputs 0 immediately.
- FAST_MUL_EN build: mul 0xFFFFFFFF × 3 → 0xFFFFFFFD with 1-cycle latency.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, function encodings and FSM states for alu_muldiv
package alu_pkg;
    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_RSV = 2'b11;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // Wide enough for any supported data_width; callers truncate with a size cast
    localparam logic [63:0] DIV0_QUOT = '1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative shift-add multiplier and restoring divider on magnitudes,
// with the sign fix-up applied combinationally on the final step.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int data_width    = 32,
    parameter int mul_step_bits = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  start,
    input  logic [2:0]            funct3,
    input  logic [data_width-1:0] a,
    input  logic [data_width-1:0] b,
    output logic                  done,
    output logic [data_width-1:0] res
);
    localparam int W  = data_width;
    localparam int S  = mul_step_bits;
    localparam int CW = $clog2(W) + 1;

    logic            run, is_div, sel, neg_x, neg_a, na, nb, ge;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    d, mag_a, mag_b, r;
    logic [2*W-1:0]  acc, nxt, p;
    logic [W+S-1:0]  madd;
    logic [W:0]      r_sh;

    assign na    = a[W-1] && (funct3[2] ? !funct3[0] : funct3[1:0] != 2'b11);
    assign nb    = b[W-1] && (funct3[2] ? !funct3[0] : !funct3[1]);
    assign mag_a = na ? -a : a;
    assign mag_b = nb ? -b : b;
    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    assign madd  = {{S{1'b0}}, acc[2*W-1:W]} + {{S{1'b0}}, d} * {{W{1'b0}}, acc[S-1:0]};
    assign r_sh  = {acc[2*W-1:W], acc[W-1]};
    assign ge    = r_sh >= {1'b0, d};
    assign r     = ge ? W'(r_sh - {1'b0, d}) : r_sh[W-1:0];
    assign nxt   = is_div ? {r, acc[W-2:0], ge} : {madd, acc[W-1:S]};
    // Low half of the negated 2W value is also the negated quotient
    assign p     = neg_x ? -nxt : nxt;
    assign res   = !sel ? p[W-1:0] : is_div ? (neg_a ? -nxt[2*W-1:W] : nxt[2*W-1:W]) : p[2*W-1:W];
    assign done  = run && cnt == CW'(1);

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            run    <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            d      <= '0;
            is_div <= 1'b0;
            sel    <= 1'b0;
            neg_x  <= 1'b0;
            neg_a  <= 1'b0;
        end else if (flush) begin
            run <= 1'b0;
        end else if (start) begin
            run    <= 1'b1;
            cnt    <= funct3[2] ? CW'(W) : CW'(W / S);
            acc    <= {{W{1'b0}}, funct3[2] ? mag_a : mag_b};
            d      <= funct3[2] ? mag_b : mag_a;
            is_div <= funct3[2];
            sel    <= funct3[2] ? funct3[1] : funct3 != F3_MUL;
            neg_x  <= na ^ nb;
            neg_a  <= na;
        end else if (run) begin
            acc <= nxt;
            cnt <= cnt - CW'(1);
            run <= !done;
        end
endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: handshaked EX-stage ALU with iterative RV32M multiply/divide.
// FAST_MUL_EN selects a single-cycle combinational multiplier for MUL*.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int data_width    = 32,
    parameter int mul_step_bits = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            alu_op,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic [data_width-1:0] operand_A,
    input  logic [data_width-1:0] operand_B,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [data_width-1:0] result,
    output logic                  zero_flag,
    output logic                  busy
);
    localparam int W  = data_width;
    localparam int SW = $clog2(W);

    state_t        state;
    logic          is_m, div0, iter_op, accept, it_done;
    logic [W-1:0]  base_res, it_res, m_res;
    logic [SW-1:0] shamt;

    assign shamt    = operand_B[SW-1:0];
    assign is_m     = alu_op == ALUOP_R && funct7 == F7_MULDIV;
    assign div0     = is_m && funct3[2] && operand_B == '0;
    assign in_ready = !reset && (state == IDLE || (state == DONE && out_ready));
    assign accept   = in_valid && in_ready && !flush;
    assign busy     = state == BUSY;

`ifdef FAST_MUL_EN
    logic [2*W-1:0] ax, bx, prod;
    // Sign-extending to 2W makes one truncated product right for all signedness mixes
    assign ax      = {{W{funct3[1:0] != 2'b11 && operand_A[W-1]}}, operand_A};
    assign bx      = {{W{!funct3[1] && operand_B[W-1]}}, operand_B};
    assign prod    = ax * bx;
    assign iter_op = is_m && funct3[2] && !div0;
    assign m_res   = funct3[2] ? (funct3[1] ? operand_A : W'(DIV0_QUOT))
                   : funct3 == F3_MUL ? prod[W-1:0] : prod[2*W-1:W];
`else
    assign iter_op = is_m && !div0;
    assign m_res   = funct3[1] ? operand_A : W'(DIV0_QUOT);
`endif

    always_comb begin
        base_res = '0;
        if (alu_op == ALUOP_ADD)
            base_res = operand_A + operand_B;
        else if (alu_op == ALUOP_SUB)
            base_res = operand_A - operand_B;
        else if (is_m)
            base_res = m_res;
        else if (alu_op == ALUOP_R && funct7 == F7_ALT)
            base_res = funct3 == F3_ADD ? operand_A - operand_B
                     : funct3 == F3_SR ? W'($signed(operand_A) >>> shamt) : '0;
        else if (alu_op == ALUOP_R && funct7 == F7_BASE)
            case (funct3)
                F3_ADD:  base_res = operand_A + operand_B;
                F3_SLL:  base_res = operand_A << shamt;
                F3_SLT:  base_res = {{(W-1){1'b0}}, $signed(operand_A) < $signed(operand_B)};
                F3_SLTU: base_res = {{(W-1){1'b0}}, operand_A < operand_B};
                F3_XOR:  base_res = operand_A ^ operand_B;
                F3_SR:   base_res = operand_A >> shamt;
                F3_OR:   base_res = operand_A | operand_B;
                default: base_res = operand_A & operand_B;
            endcase
    end

    muldiv_iter #(.data_width(W), .mul_step_bits(mul_step_bits)) u_iter (
        .clk    (clk),
        .reset  (reset),
        .flush  (flush),
        .start  (accept && iter_op),
        .funct3 (funct3),
        .a      (operand_A),
        .b      (operand_B),
        .done   (it_done),
        .res    (it_res)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero_flag <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else if (accept) begin
            state     <= iter_op ? BUSY : DONE;
            out_valid <= !iter_op;
            if (!iter_op) begin
                result    <= base_res;
                zero_flag <= base_res == '0;
            end
        end else if (state == BUSY && it_done) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= it_res;
            zero_flag <= it_res == '0;
        end else if (state == DONE && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed and randomized checks of alu_muldiv against a 64-bit arithmetic model
module tb_alu_muldiv;
    localparam int W    = 32;
    localparam int STEP = 1;
`ifdef FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic         clk = 0, reset = 0, flush = 0, in_valid = 0, out_ready = 0;
    logic         in_ready, out_valid, zero_flag, busy;
    logic [1:0]   alu_op = 0;
    logic [2:0]   funct3 = 0;
    logic [6:0]   funct7 = 0;
    logic [W-1:0] operand_A = 0, operand_B = 0, result;
    int           n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    alu_muldiv #(.data_width(W), .mul_step_bits(STEP)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .funct3    (funct3),
        .funct7    (funct7),
        .operand_A (operand_A),
        .operand_B (operand_B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero_flag (zero_flag),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_res(input logic [1:0] op, input logic [2:0] f3,
                                             input logic [6:0] f7, input logic [W-1:0] a, input logic [W-1:0] b);
        longint     sa, sb, ua, ub;
        logic [63:0] p;
        int         sh;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        sh = int'(b[4:0]);
        if (op == 2'b00) return a + b;
        if (op == 2'b01) return a - b;
        if (op != 2'b10) return '0;
        if (f7 == 7'h01) begin
            if (f3[2] && b == 0) return f3[1] ? a : '1;
            case (f3)
                3'd0:    p = sa * sb;
                3'd1:    p = (sa * sb) >> 32;
                3'd2:    p = (sa * ub) >> 32;
                3'd3:    p = ({32'b0, a} * {32'b0, b}) >> 32;
                3'd4:    p = sa / sb;
                3'd5:    p = ua / ub;
                3'd6:    p = sa % sb;
                default: p = ua % ub;
            endcase
            return p[W-1:0];
        end
        if (f7 == 7'h20) begin
            p = sa >>> sh;
            return f3 == 3'd0 ? a - b : f3 == 3'd5 ? p[W-1:0] : '0;
        end
        if (f7 != 7'h00) return '0;
        case (f3)
            3'd0:    return a + b;
            3'd1:    return a << sh;
            3'd2:    return (sa < sb) ? 1 : 0;
            3'd3:    return (ua < ub) ? 1 : 0;
            3'd4:    return a ^ b;
            3'd5:    return a >> sh;
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic [W-1:0] b);
        if (op != 2'b10 || f7 != 7'h01 || (f3[2] && b == 0)) return 1;
        if (f3[2]) return W + 1;
        return FAST ? 1 : W / STEP + 1;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0:       return '0;
            1:       return 1;
            2:       return '1;
            3:       return 32'h8000_0000;
            4:       return 32'h7fff_ffff;
            5:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    task automatic do_op(input string tag, input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] exp, input int hold);
        int lat, n, bcnt, viol;
        lat = ref_lat(op, f3, f7, b);
        @(negedge clk);
        check({tag, "_rdy"}, 32'(in_ready), 1);
        alu_op = op; funct3 = f3; funct7 = f7; operand_A = a; operand_B = b;
        in_valid = 1; out_ready = 0;
        @(posedge clk);
        #1 in_valid = 0;
        n = 0; bcnt = 0; viol = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (out_valid) break;
            bcnt += int'(busy);
            viol += int'(in_ready);
        end
        check({tag, "_lat"}, n, lat);
        check({tag, "_busy"}, bcnt, lat - 1);
        check({tag, "_rdy_busy"}, viol, 0);
        check({tag, "_res"}, result, exp);
        check({tag, "_zf"}, 32'(zero_flag), 32'(exp == 0));
        repeat (hold) begin
            @(negedge clk);
            check({tag, "_hold"}, result, exp);
            check({tag, "_hold_rdy"}, 32'(in_ready), 0);
        end
        out_ready = 1;
        #1 check({tag, "_rdy_rise"}, 32'(in_ready), 1);
        @(posedge clk);
        #1 out_ready = 0;
        check({tag, "_drain"}, 32'(out_valid), 0);
    endtask

    task automatic start_div(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        alu_op = 2'b10; funct3 = 3'd4; funct7 = 7'h01; operand_A = a; operand_B = b;
        in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        #1 reset = 1;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_result", result, 0);
        check("rst_zf", 32'(zero_flag), 0);
        check("rst_busy", 32'(busy), 0);
        reset = 0;
        #1 check("rst_rdy", 32'(in_ready), 1);

        // back-to-back base ops
        @(negedge clk);
        out_ready = 1; alu_op = 2'b10; funct7 = 7'h00; funct3 = 3'd0;
        operand_A = 7; operand_B = 5; in_valid = 1;
        check("b2b_rdy0", 32'(in_ready), 1);
        @(negedge clk);
        check("b2b_v0", 32'(out_valid), 1);
        check("b2b_res0", result, 12);
        check("b2b_zf0", 32'(zero_flag), 0);
        check("b2b_rdy1", 32'(in_ready), 1);
        funct7 = 7'h20; operand_A = 5; operand_B = 5;
        @(negedge clk);
        check("b2b_v1", 32'(out_valid), 1);
        check("b2b_res1", result, 0);
        check("b2b_zf1", 32'(zero_flag), 1);
        check("b2b_rdy2", 32'(in_ready), 1);
        in_valid = 0;
        @(negedge clk);
        check("b2b_idle", 32'(out_valid), 0);
        out_ready = 0;

        do_op("mulh",    2'b10, 3'd1, 7'h01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
        do_op("div",     2'b10, 3'd4, 7'h01, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, 0);
        do_op("rem",     2'b10, 3'd6, 7'h01, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, 0);
        do_op("divu0",   2'b10, 3'd5, 7'h01, 100, 0, 32'hFFFF_FFFF, 0);
        do_op("remu0",   2'b10, 3'd7, 7'h01, 100, 0, 100, 0);
        do_op("div_ovf", 2'b10, 3'd4, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        do_op("rem_ovf", 2'b10, 3'd6, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        do_op("mul_bp",  2'b10, 3'd0, 7'h01, 32'hFFFF_FFFF, 3, 32'hFFFF_FFFD, 5);
        do_op("mulhu",   2'b10, 3'd3, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        do_op("mulhsu",  2'b10, 3'd2, 7'h01, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFF, 0);
        do_op("sra",     2'b10, 3'd5, 7'h20, 32'h8000_0000, 4, 32'hF800_0000, 1);
        do_op("slt",     2'b10, 3'd2, 7'h00, 32'hFFFF_FFFF, 1, 1, 0);
        do_op("sltu",    2'b10, 3'd3, 7'h00, 32'hFFFF_FFFF, 1, 0, 0);
        do_op("ill_f3",  2'b10, 3'd1, 7'h20, 32'h1234_5678, 3, 0, 0);
        do_op("rsv_op",  2'b11, 3'd0, 7'h00, 32'h1234_5678, 3, 0, 0);
        do_op("ldst",    2'b00, 3'd7, 7'h7F, 32'h0000_1000, 32'h0000_0024, 32'h0000_1024, 0);

        // flush mid-divide
        start_div(1000, 7);
        repeat (9) @(negedge clk);
        check("fl_busy", 32'(busy), 1);
        flush = 1;
        @(posedge clk);
        #1 flush = 0;
        check("fl_rdy", 32'(in_ready), 1);
        check("fl_busy_clr", 32'(busy), 0);
        cnt = 0;
        repeat (40) begin @(negedge clk); cnt += int'(out_valid); end
        check("fl_no_valid", cnt, 0);

        // flush on the completing cycle wins
        start_div(1000, 7);
        repeat (32) @(negedge clk);
        check("fl_last_busy", 32'(busy), 1);
        flush = 1;
        @(posedge clk);
        #1 flush = 0;
        check("fl_last_valid", 32'(out_valid), 0);
        cnt = 0;
        repeat (5) begin @(negedge clk); cnt += int'(out_valid); end
        check("fl_last_nv", cnt, 0);

        // request alongside flush is not accepted
        @(negedge clk);
        alu_op = 2'b00; operand_A = 1; operand_B = 1; in_valid = 1; flush = 1;
        @(posedge clk);
        #1 in_valid = 0; flush = 0;
        check("fl_req_valid", 32'(out_valid), 0);

        // async reset mid-operation
        do_op("pre_rst", 2'b00, 3'd0, 7'h00, 9, 9, 18, 0);
        start_div(1000, 7);
        repeat (5) @(negedge clk);
        check("rst_mid_busy", 32'(busy), 1);
        check("rst_mid_hold", result, 18);
        #2 reset = 1;
        #1;
        check("arst_valid", 32'(out_valid), 0);
        check("arst_result", result, 0);
        check("arst_zf", 32'(zero_flag), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_rdy", 32'(in_ready), 0);
        @(negedge clk);
        reset = 0;
        #1 check("arst_rdy_rel", 32'(in_ready), 1);
        cnt = 0;
        repeat (40) begin @(negedge clk); cnt += int'(out_valid); end
        check("arst_no_valid", cnt, 0);

        for (int i = 0; i < 60; i++) begin
            logic [1:0]   op;
            logic [2:0]   f3;
            logic [6:0]   f7;
            logic [W-1:0] a, b;
            op = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
            case ($urandom_range(0, 4))
                0:       f7 = 7'h00;
                1:       f7 = 7'h20;
                2, 3:    f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            f3 = 3'($urandom);
            a = pick();
            b = pick();
            do_op("rnd", op, f3, f7, a, b, ref_res(op, f3, f7, a, b), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
